// File: rtl/spi_reg_bridge.sv
// ============================================================================
//  Module   : spi_reg_bridge
//  Purpose  : SPI mode-0 slave turning one command/data frame into one
//             single-cycle register read or write strobe.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    output logic [7:0] data_write,
    input  logic [7:0] data_read
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_RD_REQ = 3'd2;
    localparam logic [2:0] ST_RD_CAP = 3'd3;
    localparam logic [2:0] ST_RDATA  = 3'd4;
    localparam logic [2:0] ST_WDATA  = 3'd5;
    localparam logic [2:0] ST_WR     = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    logic [SYNC_STAGES:0]   sclk_pipe_q, sclk_pipe_d;
    logic [SYNC_STAGES-1:0] cs_pipe_q, cs_pipe_d;
    logic [SYNC_STAGES-1:0] mosi_pipe_q, mosi_pipe_d;
    logic [SYNC_STAGES:0]   init_q, init_d;
    logic                   armed_q, armed_d;
    logic [2:0]             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [7:0]             tx_q, tx_d;
    logic [5:0]             addr_q, addr_d;
    logic [7:0]             data_write_q, data_write_d;
    logic                   read_q, read_d;
    logic                   write_q, write_d;

    logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;

    assign sclk_s    = sclk_pipe_q[SYNC_STAGES-1];
    assign cs_s      = cs_pipe_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_pipe_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_s & sclk_pipe_q[SYNC_STAGES];

    always_comb begin
        sclk_pipe_d = {sclk_pipe_q[SYNC_STAGES-1:0], sclk};
        cs_pipe_d   = {cs_pipe_q[SYNC_STAGES-2:0], cs_n};
        mosi_pipe_d = {mosi_pipe_q[SYNC_STAGES-2:0], mosi};
        init_d      = {init_q[SYNC_STAGES-1:0], 1'b1};
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        // Only arm once the synchronisers hold real samples of a high cs_n,
        // so a frame already running at reset release is never joined.
        armed_d      = armed_q | (init_q[SYNC_STAGES] & cs_s);

        if (cs_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                        shift_d   = 7'd0;
                        armed_d   = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {shift_q[5:0], mosi_s};
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = {shift_q[4:0], mosi_s};
                            if (shift_q[6]) begin
                                state_d = ST_WDATA;
                            end else begin
                                state_d = ST_RD_REQ;
                                read_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_RD_REQ: state_d = ST_RD_CAP;
                ST_RD_CAP: begin
                    tx_d    = data_read;
                    state_d = ST_RDATA;
                end
                ST_RDATA: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = ST_DONE;
                    end else if (sclk_fall && bit_cnt_q != 3'd0) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {shift_q[5:0], mosi_s};
                        if (bit_cnt_q == 3'd7) begin
                            data_write_d = {shift_q, mosi_s};
                            write_d      = 1'b1;
                            state_d      = ST_WR;
                        end
                    end
                end
                ST_WR:   state_d = ST_DONE;
                default: state_d = ST_DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_pipe_q  <= '0;
            cs_pipe_q    <= '1;
            mosi_pipe_q  <= '0;
            init_q       <= '0;
            armed_q      <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            tx_q         <= 8'd0;
            addr_q       <= 6'd0;
            data_write_q <= 8'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            sclk_pipe_q  <= sclk_pipe_d;
            cs_pipe_q    <= cs_pipe_d;
            mosi_pipe_q  <= mosi_pipe_d;
            init_q       <= init_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

    assign miso       = (state_q == ST_RDATA) & ~cs_s & tx_q[7];
    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
// ============================================================================
//  Module   : tb_spi_reg_bridge
//  Purpose  : Directed scoreboard bench for spi_reg_bridge.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_reg_bridge;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi;
    logic       miso, read, write;
    logic [5:0] addr;
    logic [7:0] data_write, data_read, rd_model;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [13:0] wq[$];
    logic [5:0]  rq[$];
    logic [13:0] w_exp;
    logic [5:0]  r_exp;
    logic [7:0]  rx;

    spi_reg_bridge #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read)
    );

    always #5 clk = ~clk;

    always @(posedge clk) data_read <= read ? rd_model : 8'h00;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Strobe monitor: every strobe must match the head of its queue.
    always @(negedge clk) begin
        if (write) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {2'b0, addr, data_write}, 16'hFFFF);
            end else begin
                w_exp = wq.pop_front();
                chk("write_addr_data", {2'b0, addr, data_write}, {2'b0, w_exp});
                chk("write_no_read", {15'd0, read}, 16'd0);
            end
        end
        if (read) begin
            if (rq.size() == 0) begin
                chk("unexpected_read", {10'd0, addr}, 16'hFFFF);
            end else begin
                r_exp = rq.pop_front();
                chk("read_addr", {10'd0, addr}, {10'd0, r_exp});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            wait_clk(HALF);
            r = {r[6:0], miso};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_start;
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end;
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_miso"},  {15'd0, miso},  16'd0);
        chk({tag, "_read"},  {15'd0, read},  16'd0);
        chk({tag, "_write"}, {15'd0, write}, 16'd0);
        chk({tag, "_addr"},  {10'd0, addr},  16'd0);
        chk({tag, "_wdata"}, {8'd0, data_write}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; rd_model = 8'h00;
        wait_clk(5);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // sclk activity with cs_n high must never produce a strobe
        for (int i = 0; i < 100; i++) begin
            if (i % 8 == 0) sclk = ~sclk;
            mosi = i[3];
            wait_clk(1);
        end
        sclk = 1'b0;
        check_idle_outputs("cs_high_toggle");

        // write 0x81 / 0xA5
        wq.push_back({6'h01, 8'hA5});
        cs_start;
        spi_bits(8'h81, 8, rx); chk("wr1_rx0", {8'd0, rx}, 16'h0000);
        spi_bits(8'hA5, 8, rx); chk("wr1_rx1", {8'd0, rx}, 16'h0000);
        cs_end;
        chk("wr1_addr_hold",  {10'd0, addr},     16'h0001);
        chk("wr1_wdata_hold", {8'd0, data_write}, 16'h00A5);

        // read 0x0D returning 0x3C
        rq.push_back(6'h0D);
        rd_model = 8'h3C;
        cs_start;
        spi_bits(8'h0D, 8, rx); chk("rd1_rx0", {8'd0, rx}, 16'h0000);
        spi_bits(8'h00, 8, rx); chk("rd1_rx1", {8'd0, rx}, 16'h003C);
        cs_end;
        chk("rd1_miso_after", {15'd0, miso}, 16'd0);

        // aborted write after 12 bits, then a complete write
        cs_start;
        spi_bits(8'h85, 8, rx);
        spi_bits(8'hF0, 4, rx);
        cs_end;
        chk("abort_addr", {10'd0, addr}, 16'h0005);
        chk("abort_wdata_kept", {8'd0, data_write}, 16'h00A5);
        wq.push_back({6'h02, 8'h5A});
        cs_start;
        spi_bits(8'h82, 8, rx);
        spi_bits(8'h5A, 8, rx);
        cs_end;

        // 24-bit frame: trailing byte ignored
        wq.push_back({6'h0C, 8'h01});
        cs_start;
        spi_bits(8'h8C, 8, rx);
        spi_bits(8'h01, 8, rx);
        spi_bits(8'hFF, 8, rx); chk("long_rx2", {8'd0, rx}, 16'h0000);
        cs_end;
        chk("long_wdata", {8'd0, data_write}, 16'h0001);

        // reset during byte 1 of a read frame
        rq.push_back(6'h0A);
        rd_model = 8'hFF;
        cs_start;
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h00, 3, rx); chk("rstmid_rx_pre", {8'd0, rx}, 16'h0007);
        wait_clk(2);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("rst_mid");
        wait_clk(3);
        rst_n = 1'b1;
        spi_bits(8'hFF, 5, rx); chk("rstmid_rx_post", {8'd0, rx}, 16'h0000);
        cs_end;
        chk("rstmid_addr", {10'd0, addr}, 16'h0000);

        rq.push_back(6'h0A);
        rd_model = 8'h96;
        cs_start;
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h00, 8, rx); chk("rd2_rx1", {8'd0, rx}, 16'h0096);
        cs_end;

        wait_clk(10);
        chk("wq_drained", wq.size(), 16'd0);
        chk("rq_drained", rq.size(), 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
